cpu_move_gen: RTL and testbench

CPU_MOVE_GEN -- requirements
Module: cpu_move_gen

---
 rtl/cpu_move_gen.sv | 105 ++++++++++
 tb/tb_cpu_move_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cpu_move_gen.sv
// Computer-move generator: clears the first set bit of a captured 16-bit board, scanning from a start index.
// Optional CPU_MOVE_LFSR_EN selects an LFSR-derived start index instead of the deterministic next-index register.
module cpu_move_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] A,
    output logic [15:0] B,
    output logic [3:0]  idx,
    output logic        valid,
    output logic        busy,
    output logic        none
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state_q;
    logic [15:0] a_q;
    logic [3:0]  p_q;
    logic [3:0]  cnt_q;
    logic [3:0]  start_idx_d;
    logic [15:0] clr_mask_d;

    assign clr_mask_d = 16'h0001 << p_q;

`ifdef CPU_MOVE_LFSR_EN
    logic [15:0] lfsr_q;

    // Fibonacci form, taps 16,14,13,11 mapped onto a right shift.
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    assign start_idx_d = lfsr_q[3:0];
`else
    logic [3:0] nxt_q;

    assign start_idx_d = nxt_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            B       <= '0;
            idx     <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            none    <= 1'b0;
`ifndef CPU_MOVE_LFSR_EN
            nxt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        p_q     <= start_idx_d;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (a_q[p_q]) begin
                        B       <= a_q & ~clr_mask_d;
                        idx     <= p_q;
                        none    <= 1'b0;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= DONE;
`ifndef CPU_MOVE_LFSR_EN
                        nxt_q   <= p_q + 4'd1;
`endif
                    end else if (cnt_q == 4'd15) begin
                        // Sixteenth clear bit: board is full, report no move.
                        B       <= a_q;
                        idx     <= '0;
                        none    <= 1'b1;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        p_q   <= p_q + 4'd1;
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    valid   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_move_gen.sv
// Directed bench for cpu_move_gen; the LFSR start-index build is exercised when CPU_MOVE_LFSR_EN is defined.
module tb_cpu_move_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B;
    logic [3:0]  idx;
    logic        valid;
    logic        busy;
    logic        none;

    int unsigned tests = 0;
    int unsigned fails = 0;

    cpu_move_gen dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .idx   (idx),
        .valid (valid),
        .busy  (busy),
        .none  (none)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one move; A is inverted after capture to prove it is ignored.
    task automatic move(input string tag, input logic [15:0] a, input int exp_lat,
                        input logic [15:0] exp_b, input logic [3:0] exp_idx,
                        input logic exp_none, input bit hold_start);
        int k;
        int busy_cnt;
        A     = a;
        start = 1'b1;
        tick();
        A     = ~a;
        start = hold_start;
        k        = 0;
        busy_cnt = busy ? 1 : 0;
        while (!valid && k < 40) begin
            tick();
            k++;
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        check({tag, "_lat"}, k, exp_lat);
        check({tag, "_busycyc"}, busy_cnt, exp_lat);
        check({tag, "_B"}, B, exp_b);
        check({tag, "_idx"}, idx, exp_idx);
        check({tag, "_none"}, none, exp_none);
        tick();
        check({tag, "_valid_drop"}, valid, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_hold_B"}, B, exp_b);
    endtask

`ifdef CPU_MOVE_LFSR_EN
    logic [15:0] lfsr_m;
    always @(posedge clk) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end
`endif

    initial begin
        tick();
        tick();
        check("rst_B", B, 16'h0000);
        check("rst_idx", idx, 4'd0);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_none", none, 1'b0);
        reset = 1'b0;
        tick();

`ifdef CPU_MOVE_LFSR_EN
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] a;
            logic [3:0]  s;
            logic [3:0]  e;
            int          lat;
            a   = 16'($urandom_range(1, 65535));
            s   = lfsr_m[3:0];
            e   = s;
            lat = 1;
            while (!a[e]) begin
                e   = e + 4'd1;
                lat++;
            end
            move("lfsr", a, lat, a & ~(16'h0001 << e), e, 1'b0, 1'b0);
        end
`else
        move("m1", 16'h0007, 1, 16'h0006, 4'd0, 1'b0, 1'b0);
        move("m2", 16'h0006, 1, 16'h0004, 4'd1, 1'b0, 1'b0);
        move("m3", 16'h0004, 1, 16'h0000, 4'd2, 1'b0, 1'b0);
        move("empty", 16'h0000, 16, 16'h0000, 4'd0, 1'b1, 1'b0);

        // Outputs hold while idle and A changes.
        A = 16'hFFFF;
        tick();
        tick();
        check("hold_idle_B", B, 16'h0000);
        check("hold_idle_none", none, 1'b1);

        // next-index still 3: scan 3..15 then wraps to bit 0; start held to show it is not queued.
        move("wrap", 16'h0001, 14, 16'h0000, 4'd0, 1'b0, 1'b1);
        tick();
        check("noqueue_busy", busy, 1'b0);

        // next-index now 1: abort a scan with reset.
        A     = 16'h8000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", valid, 1'b0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (valid) seen++;
            end
            check("abort_no_pulse", seen, 0);
        end
        move("post_rst", 16'h8000, 16, 16'h0000, 4'd15, 1'b0, 1'b0);
        move("full", 16'hFFFF, 1, 16'hFFFE, 4'd0, 1'b0, 1'b0);
        move("skip7", 16'h0100, 8, 16'h0000, 4'd8, 1'b0, 1'b0);

        // Reset wins over start in the same cycle.
        A     = 16'h0001;
        start = 1'b1;
        reset = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        check("rst_prio_busy", busy, 1'b0);
        tick();
        check("rst_prio_valid", valid, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
